commit_retire_buffer: RTL and testbench

//  In-order retirement buffer (small ROB) that produces the commit stream consumed by the write-back stage in OoO mode.

---
 rtl/ooo_pkg.sv | 24 ++
 rtl/commit_retire_buffer.sv | 117 +++++++++++
 tb/tb_commit_retire_buffer.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/ooo_pkg.sv
// Shared out-of-order types: reorder-buffer entries and the commit packet
// handed to write-back.
package ooo_pkg;

  localparam int ROB_DEPTH = 8;
  localparam int ROB_TAG_W = $clog2(ROB_DEPTH);

  typedef logic [ROB_TAG_W-1:0] rob_tag_t;

  typedef struct packed {
    logic        valid;
    logic        done;
    logic [4:0]  rd_addr;
    logic [31:0] data;
  } rob_entry_t;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd_addr;
    logic [31:0] result;
    rob_tag_t    tag;
  } commit_pkt_t;

endpackage

// File: rtl/commit_retire_buffer.sv
// In-order retirement buffer: allocate in program order, complete by tag,
// retire one completed head entry per cycle as a registered commit packet.
module commit_retire_buffer
  import ooo_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int TAG_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             alloc_valid_i,
  input  logic [4:0]       alloc_rd_addr_i,
  output logic             alloc_ready_o,
  output logic [TAG_W-1:0] alloc_tag_o,
  input  logic             cpl_valid_i,
  input  logic [TAG_W-1:0] cpl_tag_i,
  input  logic [31:0]      cpl_result_i,
  output logic             commit_valid_o,
  output logic [4:0]       commit_rd_addr_o,
  output logic [31:0]      commit_result_o,
  output logic [TAG_W-1:0] commit_tag_o,
  output logic [TAG_W:0]   count_o,
  output logic             empty_o
);

  rob_entry_t       ent_q [DEPTH];
  logic [TAG_W:0]   head_q;
  logic [TAG_W:0]   tail_q;
  commit_pkt_t      commit_q;

  logic [TAG_W-1:0] head_idx;
  logic [TAG_W-1:0] tail_idx;
  logic             full;
  logic             head_ready;
  logic             do_alloc;
  logic             do_cpl;

  assign head_idx   = head_q[TAG_W-1:0];
  assign tail_idx   = tail_q[TAG_W-1:0];
  // Top pointer bit is the wrap flag: same index, different lap means full.
  assign full       = (head_idx == tail_idx) &&
                      (head_q[TAG_W] != tail_q[TAG_W]);
  assign head_ready = ent_q[head_idx].valid && ent_q[head_idx].done;
  assign do_alloc   = alloc_valid_i && !full;
  assign do_cpl     = cpl_valid_i && ent_q[cpl_tag_i].valid;

  assign alloc_ready_o    = !full;
  assign alloc_tag_o      = tail_idx;
  assign count_o          = tail_q - head_q;
  assign empty_o          = (tail_q == head_q);
  assign commit_valid_o   = commit_q.valid;
  assign commit_rd_addr_o = commit_q.rd_addr;
  assign commit_result_o  = commit_q.result;
  assign commit_tag_o     = TAG_W'(commit_q.tag);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q   <= '0;
      tail_q   <= '0;
      commit_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i].valid <= 1'b0;
        ent_q[i].done  <= 1'b0;
      end
    end else if (flush_i) begin
      head_q         <= '0;
      tail_q         <= '0;
      commit_q.valid <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i].valid <= 1'b0;
        ent_q[i].done  <= 1'b0;
      end
    end else begin
      if (head_ready) begin
        commit_q.valid   <= 1'b1;
        commit_q.rd_addr <= ent_q[head_idx].rd_addr;
        commit_q.result  <= ent_q[head_idx].data;
        commit_q.tag     <= rob_tag_t'(head_idx);
        head_q           <= head_q + 1'b1;
      end else begin
        commit_q.valid <= 1'b0;
      end
      if (do_cpl) begin
        ent_q[cpl_tag_i].done <= 1'b1;
        ent_q[cpl_tag_i].data <= cpl_result_i;
      end
      // Retire clear wins over a same-cycle completion of the head.
      if (head_ready) begin
        ent_q[head_idx].valid <= 1'b0;
        ent_q[head_idx].done  <= 1'b0;
      end
      if (do_alloc) begin
        ent_q[tail_idx].valid   <= 1'b1;
        ent_q[tail_idx].done    <= 1'b0;
        ent_q[tail_idx].rd_addr <= alloc_rd_addr_i;
        tail_q                  <= tail_q + 1'b1;
      end
    end
  end

  a_no_alloc_full: assert property (
    @(posedge clk_i) disable iff (rst_i || flush_i)
    !(alloc_valid_i && full)
  ) else $warning("rob: alloc request while full was dropped");

  a_cpl_live_tag: assert property (
    @(posedge clk_i) disable iff (rst_i || flush_i)
    !(cpl_valid_i && !ent_q[cpl_tag_i].valid)
  ) else $warning("rob: completion to unallocated tag dropped");

  a_commit_done: assert property (
    @(posedge clk_i) disable iff (rst_i)
    commit_valid_o |-> $past(head_ready)
  ) else $error("rob: commit without a completed head entry");

endmodule

// File: tb/tb_commit_retire_buffer.sv
// Directed bench for commit_retire_buffer: in-order, out-of-order,
// full/wrap, flush and corner retirement sequences.
module tb_commit_retire_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        alloc_valid;
  logic [4:0]  alloc_rd;
  logic        alloc_ready;
  logic [2:0]  alloc_tag;
  logic        cpl_valid;
  logic [2:0]  cpl_tag;
  logic [31:0] cpl_result;
  logic        commit_valid;
  logic [4:0]  commit_rd;
  logic [31:0] commit_result;
  logic [2:0]  commit_tag;
  logic [3:0]  count;
  logic        empty;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  commit_retire_buffer dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .flush_i          (flush),
    .alloc_valid_i    (alloc_valid),
    .alloc_rd_addr_i  (alloc_rd),
    .alloc_ready_o    (alloc_ready),
    .alloc_tag_o      (alloc_tag),
    .cpl_valid_i      (cpl_valid),
    .cpl_tag_i        (cpl_tag),
    .cpl_result_i     (cpl_result),
    .commit_valid_o   (commit_valid),
    .commit_rd_addr_o (commit_rd),
    .commit_result_o  (commit_result),
    .commit_tag_o     (commit_tag),
    .count_o          (count),
    .empty_o          (empty)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_commit(input string tag, input logic [4:0] rd,
                            input logic [31:0] res, input logic [2:0] t);
    check({tag, ".valid"}, 32'(commit_valid), 32'd1);
    check({tag, ".rd"}, 32'(commit_rd), 32'(rd));
    check({tag, ".result"}, commit_result, res);
    check({tag, ".tag"}, 32'(commit_tag), 32'(t));
  endtask

  task automatic alloc(input logic [4:0] rd, input logic [2:0] exp_tag);
    alloc_valid = 1'b1;
    alloc_rd    = rd;
    check("alloc_tag", 32'(alloc_tag), 32'(exp_tag));
    tick();
    alloc_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    alloc_valid = 1'b1; alloc_rd = 5'd9;
    cpl_valid = 1'b0; cpl_tag = '0; cpl_result = '0;
    // Reset held two cycles with alloc requested
    tick(); tick();
    check("rst.ready", 32'(alloc_ready), 32'd1);
    check("rst.empty", 32'(empty), 32'd1);
    check("rst.commit_valid", 32'(commit_valid), 32'd0);
    check("rst.count", 32'(count), 32'd0);
    check("rst.commit_result", commit_result, 32'd0);
    rst = 1'b0; alloc_valid = 1'b0;
    tick();
    check("rst.count_after", 32'(count), 32'd0);

    // In order
    alloc(5'd5, 3'd0);
    alloc(5'd6, 3'd1);
    alloc(5'd7, 3'd2);
    check("io.count", 32'(count), 32'd3);
    cpl_valid = 1'b1; cpl_tag = 3'd0; cpl_result = 32'hA;
    tick();
    check("io.no_bypass", 32'(commit_valid), 32'd0);
    cpl_tag = 3'd1; cpl_result = 32'hB;
    tick();
    chk_commit("io.c0", 5'd5, 32'hA, 3'd0);
    check("io.count2", 32'(count), 32'd2);
    cpl_tag = 3'd2; cpl_result = 32'hC;
    tick();
    chk_commit("io.c1", 5'd6, 32'hB, 3'd1);
    cpl_valid = 1'b0;
    tick();
    chk_commit("io.c2", 5'd7, 32'hC, 3'd2);
    tick();
    check("io.idle", 32'(commit_valid), 32'd0);
    check("io.empty", 32'(empty), 32'd1);
    check("io.hold_result", commit_result, 32'hC);

    // Out of order
    do_reset();
    check("ooo.rst_result", commit_result, 32'd0);
    alloc(5'd1, 3'd0);
    alloc(5'd2, 3'd1);
    alloc(5'd3, 3'd2);
    alloc(5'd4, 3'd3);
    cpl_valid = 1'b1;
    cpl_tag = 3'd3; cpl_result = 32'h13; tick();
    check("ooo.wait0", 32'(commit_valid), 32'd0);
    cpl_tag = 3'd2; cpl_result = 32'h12; tick();
    check("ooo.wait1", 32'(commit_valid), 32'd0);
    cpl_tag = 3'd1; cpl_result = 32'h11; tick();
    check("ooo.wait2", 32'(commit_valid), 32'd0);
    cpl_valid = 1'b0;
    tick();
    check("ooo.wait3", 32'(commit_valid), 32'd0);
    tick();
    check("ooo.wait4", 32'(commit_valid), 32'd0);
    check("ooo.count", 32'(count), 32'd4);
    cpl_valid = 1'b1; cpl_tag = 3'd0; cpl_result = 32'h10;
    tick();
    cpl_valid = 1'b0;
    check("ooo.no_bypass", 32'(commit_valid), 32'd0);
    tick(); chk_commit("ooo.c0", 5'd1, 32'h10, 3'd0);
    tick(); chk_commit("ooo.c1", 5'd2, 32'h11, 3'd1);
    tick(); chk_commit("ooo.c2", 5'd3, 32'h12, 3'd2);
    tick(); chk_commit("ooo.c3", 5'd4, 32'h13, 3'd3);
    tick();
    check("ooo.done", 32'(commit_valid), 32'd0);
    check("ooo.empty", 32'(empty), 32'd1);

    // Full and wrap
    do_reset();
    for (int i = 0; i < 8; i++) alloc(5'(10 + i), 3'(i));
    check("full.ready", 32'(alloc_ready), 32'd0);
    check("full.count", 32'(count), 32'd8);
    check("full.empty", 32'(empty), 32'd0);
    alloc_valid = 1'b1; alloc_rd = 5'd31;
    tick();
    check("full.ignored", 32'(count), 32'd8);
    cpl_valid = 1'b1; cpl_tag = 3'd0; cpl_result = 32'h20;
    tick();
    cpl_valid = 1'b0;
    check("full.still", 32'(count), 32'd8);
    tick();
    chk_commit("full.c0", 5'd10, 32'h20, 3'd0);
    check("full.refused", 32'(count), 32'd7);
    check("full.ready2", 32'(alloc_ready), 32'd1);
    alloc_valid = 1'b0;
    alloc(5'd31, 3'd0);
    check("full.count8", 32'(count), 32'd8);
    check("full.ready3", 32'(alloc_ready), 32'd0);

    // Flush
    do_reset();
    for (int i = 0; i < 5; i++) alloc(5'(1 + i), 3'(i));
    cpl_valid = 1'b1;
    cpl_tag = 3'd1; cpl_result = 32'h31; tick();
    cpl_tag = 3'd0; cpl_result = 32'h30; tick();
    cpl_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl.commit", 32'(commit_valid), 32'd0);
    check("fl.count", 32'(count), 32'd0);
    check("fl.empty", 32'(empty), 32'd1);
    check("fl.tag", 32'(alloc_tag), 32'd0);
    cpl_valid = 1'b1; cpl_tag = 3'd3; cpl_result = 32'h99;
    tick();
    cpl_valid = 1'b0;
    check("fl.stale_count", 32'(count), 32'd0);
    tick();
    check("fl.stale_commit", 32'(commit_valid), 32'd0);
    check("fl.stale_empty", 32'(empty), 32'd1);

    // Corner: rd=0 commit, and alloc+retire at count 3
    do_reset();
    alloc(5'd0, 3'd0);
    alloc(5'd3, 3'd1);
    alloc(5'd4, 3'd2);
    cpl_valid = 1'b1; cpl_tag = 3'd0; cpl_result = 32'h77;
    tick();
    cpl_valid = 1'b0;
    check("cn.count3", 32'(count), 32'd3);
    alloc(5'd9, 3'd3);
    chk_commit("cn.x0", 5'd0, 32'h77, 3'd0);
    check("cn.count_same", 32'(count), 32'd3);
    tick();
    check("cn.idle", 32'(commit_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
